// File: rtl/dmem_arbiter_if.sv
// Signal bundle between dmem_arbiter, its two requesters (CPU MEM stage and
// debug/loader port) and the single-port Data_Memory.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment view: requesters plus memory
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU MEM stage, debug port) for the single-port data memory.
// Fixed CPU priority by default; define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int   NPORTS   = 2;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              lat_we_reg, lat_we_next;
    logic [ADDR_W-1:0] lat_addr_reg, lat_addr_next;
    logic [DATA_W-1:0] lat_wdata_reg, lat_wdata_next;

    logic [NPORTS-1:0] req_vec;
    logic [NPORTS-1:0] we_vec;
    logic [ADDR_W-1:0] addr_vec  [NPORTS];
    logic [DATA_W-1:0] wdata_vec [NPORTS];
    logic [DATA_W-1:0] rdata_vec [NPORTS];
    logic [NPORTS-1:0] ready_vec;

    logic              req_any;
    logic              winner;
    logic              in_range;
    logic              capture;
    logic              rd_strobe;
    logic              wr_strobe;
    logic [DATA_W-1:0] load_data;

    assign req_vec[PORT_CPU]   = bus.cpu_req;
    assign req_vec[PORT_DBG]   = bus.dbg_req;
    assign we_vec[PORT_CPU]    = bus.cpu_we;
    assign we_vec[PORT_DBG]    = bus.dbg_we;
    assign addr_vec[PORT_CPU]  = bus.cpu_addr;
    assign addr_vec[PORT_DBG]  = bus.dbg_addr;
    assign wdata_vec[PORT_CPU] = bus.cpu_wdata;
    assign wdata_vec[PORT_DBG] = bus.dbg_wdata;

    assign req_any  = |req_vec;
    assign in_range = (lat_addr_reg < ADDR_W'(MEM_WORDS));

    // Out-of-range loads and all stores return zero to the owner.
    assign load_data = (in_range && !lat_we_reg) ? bus.mem_rdata : '0;

`ifdef DMEM_ARB_RR_EN
    logic last_grant_reg, last_grant_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= PORT_DBG;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        last_grant_next = last_grant_reg;
        if (state_reg == ST_IDLE && req_any) begin
            last_grant_next = winner;
        end
    end

    // On contention the port that did not win last time is served.
    always_comb begin
        if (&req_vec) begin
            winner = ~last_grant_reg;
        end else begin
            winner = ~req_vec[PORT_CPU];
        end
    end
`else
    assign winner = ~req_vec[PORT_CPU];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= PORT_CPU;
            lat_we_reg    <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            lat_we_reg    <= lat_we_next;
            lat_addr_reg  <= lat_addr_next;
            lat_wdata_reg <= lat_wdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        lat_we_next    = lat_we_reg;
        lat_addr_next  = lat_addr_reg;
        lat_wdata_next = lat_wdata_reg;
        capture        = 1'b0;
        rd_strobe      = 1'b0;
        wr_strobe      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_any) begin
                    state_next     = ST_ACCESS;
                    owner_next     = winner;
                    lat_we_next    = we_vec[winner];
                    lat_addr_next  = addr_vec[winner];
                    lat_wdata_next = wdata_vec[winner];
                end
            end
            ST_ACCESS: begin
                // Strobes are gated by rst so a reset here cannot corrupt memory.
                rd_strobe  = ~lat_we_reg & in_range & ~rst;
                wr_strobe  = lat_we_reg & in_range & ~rst;
                capture    = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);
            logic [DATA_W-1:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (capture && owner_reg == PORT_ID) begin
                    rdata_reg <= load_data;
                end
            end

            assign rdata_vec[gi] = rdata_reg;
            assign ready_vec[gi] = (state_reg == ST_DONE) && (owner_reg == PORT_ID);
        end
    endgenerate

    assign bus.cpu_rdata = rdata_vec[PORT_CPU];
    assign bus.dbg_rdata = rdata_vec[PORT_DBG];
    assign bus.cpu_ready = ready_vec[PORT_CPU];
    assign bus.dbg_ready = ready_vec[PORT_DBG];
    assign bus.cpu_stall = bus.cpu_req & ~ready_vec[PORT_CPU];

    assign bus.mem_read  = rd_strobe;
    assign bus.mem_write = wr_strobe;
    assign bus.mem_addr  = lat_addr_reg;
    assign bus.mem_wdata = lat_wdata_reg;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level
// reference model (arbitration rule, word memory, per-port held read data).
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Data_Memory stand-in, written only through the DUT strobes
    logic [DATA_W-1:0] mem [MEM_WORDS];
    assign bus.mem_rdata = (bus.mem_addr < MEM_WORDS) ? mem[bus.mem_addr[5:0]] : 32'hDEADBEEF;

    // Reference model state
    logic [DATA_W-1:0] ref_mem   [MEM_WORDS];
    logic [DATA_W-1:0] ref_rdata [2];
    int                ref_last;
    bit                p_req   [2];
    bit                p_we    [2];
    logic [ADDR_W-1:0] p_addr  [2];
    logic [DATA_W-1:0] p_wdata [2];
    int                obs_q [$];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                n_txn    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        bus.cpu_req   = p_req[0];
        bus.cpu_we    = p_we[0];
        bus.cpu_addr  = p_addr[0];
        bus.cpu_wdata = p_wdata[0];
        bus.dbg_req   = p_req[1];
        bus.dbg_we    = p_we[1];
        bus.dbg_addr  = p_addr[1];
        bus.dbg_wdata = p_wdata[1];
    endtask

    // Advance one clock; the memory stand-in commits a write seen before the edge.
    task automatic tick();
        logic              do_wr;
        logic [5:0]        wa;
        logic [DATA_W-1:0] wd;
        do_wr = bus.mem_write;
        wa    = bus.mem_addr[5:0];
        wd    = bus.mem_wdata;
        @(posedge clk);
        if (do_wr) mem[wa] = wd;
        @(negedge clk);
    endtask

    function automatic int pick_winner();
        if (p_req[0] && p_req[1]) begin
`ifdef DMEM_ARB_RR_EN
            return (ref_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return p_req[0] ? 0 : 1;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_ready"}, bus.cpu_ready, 0);
        chk({tag, "_dbg_ready"}, bus.dbg_ready, 0);
        chk({tag, "_mem_read"},  bus.mem_read, 0);
        chk({tag, "_mem_write"}, bus.mem_write, 0);
        chk({tag, "_mem_addr"},  bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
        chk({tag, "_dbg_rdata"}, bus.dbg_rdata, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        drive_inputs();
        tick();
        ref_last     = 1;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        bus.cpu_req = 1'b1;
        #1;
        chk("rst_stall_hi", bus.cpu_stall, 1);
        chk_reset_outputs("rst");
        bus.cpu_req = 1'b0;
        #1;
        chk("rst_stall_lo", bus.cpu_stall, 0);
        rst = 1'b0;
    endtask

    // One granted transaction from IDLE through DONE, back to IDLE.
    task automatic run_txn(input bit scramble);
        int                w;
        bit                inr;
        logic [DATA_W-1:0] exp_rd;
        drive_inputs();
        #1;
        w   = pick_winner();
        inr = (p_addr[w] < MEM_WORDS);
        chk("idle_stall", bus.cpu_stall, p_req[0]);
        chk("idle_strobes", {bus.mem_read, bus.mem_write}, 0);
        chk("idle_ready", {bus.cpu_ready, bus.dbg_ready}, 0);
        tick();
        if (scramble) begin
            if (w == 0) begin
                bus.cpu_we    = ~p_we[0];
                bus.cpu_addr  = p_addr[0] ^ 32'hC;
                bus.cpu_wdata = ~p_wdata[0];
            end else begin
                bus.dbg_we    = ~p_we[1];
                bus.dbg_addr  = p_addr[1] ^ 32'hC;
                bus.dbg_wdata = ~p_wdata[1];
            end
        end
        #1;
        chk("acc_mem_read", bus.mem_read, !p_we[w] && inr);
        chk("acc_mem_write", bus.mem_write, p_we[w] && inr);
        chk("acc_mem_addr", bus.mem_addr, p_addr[w]);
        if (p_we[w]) chk("acc_mem_wdata", bus.mem_wdata, p_wdata[w]);
        chk("acc_stall", bus.cpu_stall, p_req[0]);
        chk("acc_ready", {bus.cpu_ready, bus.dbg_ready}, 0);
        tick();
        exp_rd = (inr && !p_we[w]) ? ref_mem[p_addr[w][5:0]] : '0;
        if (inr && p_we[w]) ref_mem[p_addr[w][5:0]] = p_wdata[w];
        ref_rdata[w] = exp_rd;
        ref_last     = w;
        chk("done_cpu_ready", bus.cpu_ready, w == 0);
        chk("done_dbg_ready", bus.dbg_ready, w == 1);
        chk("done_cpu_rdata", bus.cpu_rdata, ref_rdata[0]);
        chk("done_dbg_rdata", bus.dbg_rdata, ref_rdata[1]);
        chk("done_stall", bus.cpu_stall, p_req[0] && (w != 0));
        chk("done_strobes", {bus.mem_read, bus.mem_write}, 0);
        obs_q.push_back(bus.dbg_ready ? 1 : 0);
        $display("txn %0d port=%s we=%0d addr=%0d wdata=%h rdata=%h", n_txn,
                 (w == 0) ? "cpu" : "dbg", p_we[w], p_addr[w], p_wdata[w], exp_rd);
        n_txn++;
        p_req[w] = 1'b0;
        drive_inputs();
        tick();
    endtask

    task automatic set_req(input int port, input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata);
        p_req[port]   = 1'b1;
        p_we[port]    = we;
        p_addr[port]  = addr;
        p_wdata[port] = wdata;
    endtask

    int exp_order [4];

    initial begin
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 2; i++) begin
            p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
        end
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 99;
        ref_mem[4] = 99;
        rst = 1'b1;
        drive_inputs();
        @(negedge clk);
        do_reset();

        // CPU load from address 4
        set_req(0, 1'b0, 4, 0);
        run_txn(1'b0);
        chk("cpu_load4", bus.cpu_rdata, 99);

        // Fields changed after the grant are ignored
        set_req(0, 1'b0, 4, 0);
        run_txn(1'b1);
        chk("field_chg_rdata", bus.cpu_rdata, 99);

        // Debug store then CPU load of the same word
        set_req(1, 1'b1, 8, 32'h1234);
        run_txn(1'b0);
        set_req(0, 1'b0, 8, 0);
        run_txn(1'b0);
        chk("dbg_store_cpu_load", bus.cpu_rdata, 32'h1234);

        // Out-of-range store and load
        set_req(0, 1'b1, 64, 32'h5555AAAA);
        run_txn(1'b0);
        set_req(0, 1'b0, 64, 0);
        run_txn(1'b0);
        chk("oor_load_zero", bus.cpu_rdata, 0);

        // Both ports held for four transactions
        do_reset();
        obs_q.delete();
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 2; p++)
                if (!p_req[p]) set_req(p, 1'($urandom), 16 + $urandom_range(0, 47), $urandom);
            run_txn(1'b0);
        end
        for (int k = 0; k < 4; k++) chk("simul_grant", obs_q[k], exp_order[k]);

        // Reset during the ACCESS cycle of a debug store to address 12
        do_reset();
        set_req(1, 1'b1, 12, 32'hCAFE0012);
        drive_inputs();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_acc_write", bus.mem_write, 0);
        chk("rst_acc_read", bus.mem_read, 0);
        tick();
        chk_reset_outputs("rst_acc");
        chk("rst_acc_mem12", mem[12], ref_mem[12]);
        p_req[1] = 1'b0;
        ref_last = 1;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        drive_inputs();
        rst = 1'b0;
        tick();
        chk("rst_acc_no_ready", {bus.cpu_ready, bus.dbg_ready}, 0);
        set_req(0, 1'b0, 12, 0);
        run_txn(1'b0);

        // Randomized traffic with occasional idle cycles
        for (int it = 0; it < 200; it++) begin
            for (int p = 0; p < 2; p++)
                if (!p_req[p] && ($urandom_range(0, 1) == 1))
                    set_req(p, 1'($urandom), $urandom_range(0, MEM_WORDS + 7), $urandom);
            if (!p_req[0] && !p_req[1]) begin
                drive_inputs();
                #1;
                chk("rnd_idle_stall", bus.cpu_stall, 0);
                tick();
                chk("rnd_idle_strobes", {bus.mem_read, bus.mem_write}, 0);
                chk("rnd_idle_rdata", {bus.cpu_rdata, bus.dbg_rdata}, {ref_rdata[0], ref_rdata[1]});
            end else begin
                run_txn($urandom_range(0, 3) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
